// File: rtl/pw_usb_pkg.sv
// Shared USB definitions for the UTMI transmit path: TX FSM encoding,
// CRC16-USB constants, common PID values and a byte-wide CRC16 update.
package pw_usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BUS = 3'd1,
    ST_SEND     = 3'd2,
    ST_CRC_LO   = 3'd3,
    ST_CRC_HI   = 3'd4,
    ST_DONE     = 3'd5
  } tx_state_t;

  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL  = 16'h800D;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  // One byte of reflected CRC16 (LSB of the byte enters first).
  function automatic logic [15:0] crc16_usb_byte(input logic [15:0] crc,
                                                 input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/pw_crc16_usb.sv
// Registered byte-wide CRC16-USB accumulator. clr_i reloads the seed,
// en_i folds data_i in; crc_o is the inverted (transmit-ready) value.
module pw_crc16_usb
  import pw_usb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  // Accumulator: seed on reset/clear, fold one byte per enable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      crc_q <= CRC16_INIT;
    end else if (en_i) begin
      crc_q <= crc16_usb_byte(crc_q, data_i);
    end
  end

  assign crc_o = ~crc_q;

endmodule

// File: rtl/pw_utmi_tx.sv
// UTMI transmit engine: host loads a byte buffer, a send pulse waits for a
// quiet bus and then streams the buffer under the TxValid/TxReady handshake.
// Optional feature macro PW_TX_CRC16_EN adds I_append_crc and a trailing
// CRC16 (low byte first) over bytes 1..count-1.
module pw_utmi_tx
  import pw_usb_pkg::*;
#(
  parameter int pBUF_BYTES  = 64,
  parameter int pGAP_CYCLES = 8,
  parameter int pTIMEOUT    = 4096,
  localparam int CW = $clog2(pBUF_BYTES + 1)
)(
  input  logic          fe_clk,
  input  logic          reset_n,
  input  logic [7:0]    I_wr_data,
  input  logic          I_wr_en,
  input  logic          I_clear,
  input  logic          I_send,
  input  logic          I_rxactive,
  input  logic          I_txready,
`ifdef PW_TX_CRC16_EN
  input  logic          I_append_crc,
`endif
  output logic [7:0]    O_tx_data,
  output logic          O_txvalid,
  output logic          O_drive,
  output logic          O_busy,
  output logic          O_done,
  output logic          O_error,
  output logic [CW-1:0] O_count
);

  localparam int AW = $clog2(pBUF_BYTES);
  localparam int GW = $clog2(pGAP_CYCLES + 1);
  localparam int TW = $clog2(pTIMEOUT + 1);

  tx_state_t     state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          error_q, error_d;
  logic [CW-1:0] count_q;
  logic [7:0]    rd_data_q;
  logic [7:0]    buf_mem [pBUF_BYTES];
  logic          wr_ok;
  logic          in_tx;

`ifdef PW_TX_CRC16_EN
  logic          append_q, append_d;
  logic          crc_clr, crc_en;
  logic [15:0]   crc_val;
`endif

  // Loading is only allowed while idle; clear takes priority over a write.
  assign wr_ok = (state_q == ST_IDLE) && !I_clear && I_wr_en &&
                 (count_q != CW'(pBUF_BYTES));

  // Next state, gap/timeout counters and buffer index.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    error_d = error_q;
`ifdef PW_TX_CRC16_EN
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    append_d = append_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (I_send && (count_q != '0)) begin
          state_d = ST_WAIT_BUS;
          gap_d   = '0;
          idx_d   = '0;
          error_d = 1'b0;
`ifdef PW_TX_CRC16_EN
          crc_clr  = 1'b1;
          append_d = I_append_crc;
`endif
        end
      end
      ST_WAIT_BUS: begin
        if (I_rxactive) begin
          gap_d = '0;
        end else if (gap_q == GW'(pGAP_CYCLES - 1)) begin
          state_d = ST_SEND;
          gap_d   = '0;
          tmo_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_SEND, ST_CRC_LO, ST_CRC_HI: begin
        if (I_txready) begin
          tmo_d = '0;
          if (state_q == ST_SEND) begin
`ifdef PW_TX_CRC16_EN
            crc_en = (idx_q != '0);
`endif
            if (idx_q == count_q - 1'b1) begin
              idx_d   = '0;
              state_d = ST_DONE;
`ifdef PW_TX_CRC16_EN
              if (append_q) state_d = ST_CRC_LO;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else if (state_q == ST_CRC_LO) begin
            state_d = ST_CRC_HI;
          end else begin
            state_d = ST_DONE;
          end
        end else if (tmo_q == TW'(pTIMEOUT - 1)) begin
          state_d = ST_DONE;
          error_d = 1'b1;
          idx_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
    end
  end

`ifdef PW_TX_CRC16_EN
  // Append request captured when a send is accepted.
  always_ff @(posedge fe_clk) begin
    if (!reset_n) append_q <= 1'b0;
    else          append_q <= append_d;
  end

  pw_crc16_usb u_crc (
    .clk_i  (fe_clk),
    .rst_ni (reset_n),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .data_i (rd_data_q),
    .crc_o  (crc_val)
  );
`endif

  // Byte count: cleared by reset or I_clear, bumped on each accepted write.
  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (state_q == ST_IDLE && I_clear) begin
      count_q <= '0;
    end else if (wr_ok) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Packet buffer with registered read; reading the next index makes
  // tx_data advance on the same edge that accepts the current byte.
  always_ff @(posedge fe_clk) begin
    if (wr_ok) buf_mem[count_q[AW-1:0]] <= I_wr_data;
    rd_data_q <= buf_mem[idx_d[AW-1:0]];
  end

  assign in_tx = (state_q == ST_SEND) || (state_q == ST_CRC_LO) ||
                 (state_q == ST_CRC_HI);

  // Output byte: buffer data in SEND, CRC bytes in CRC states, else zero.
  always_comb begin
    O_tx_data = 8'h00;
    case (state_q)
      ST_SEND:   O_tx_data = rd_data_q;
`ifdef PW_TX_CRC16_EN
      ST_CRC_LO: O_tx_data = crc_val[7:0];
      ST_CRC_HI: O_tx_data = crc_val[15:8];
`endif
      default:   O_tx_data = 8'h00;
    endcase
  end

  assign O_txvalid = in_tx;
  assign O_drive   = in_tx;
  assign O_busy    = (state_q != ST_IDLE);
  assign O_done    = (state_q == ST_DONE);
  assign O_error   = error_q;
  assign O_count   = count_q;

endmodule

// File: tb/tb_pw_utmi_tx.sv
// Bench for pw_utmi_tx: expected byte stream kept as a queue built from the
// bench's own copy of the buffer (plus a bit-serial CRC16 when
// PW_TX_CRC16_EN is defined), checked every cycle TxValid is high.
module tb_pw_utmi_tx;

  logic       fe_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] I_wr_data = 8'h00;
  logic       I_wr_en = 1'b0;
  logic       I_clear = 1'b0;
  logic       I_send = 1'b0;
  logic       I_rxactive = 1'b0;
  logic       I_txready;
`ifdef PW_TX_CRC16_EN
  logic       I_append_crc = 1'b0;
`endif
  logic [7:0] O_tx_data;
  logic       O_txvalid, O_drive, O_busy, O_done, O_error;
  logic [6:0] O_count;

  logic ready_fixed = 1'b0;
  logic rnd_ready = 1'b0;
  logic rnd_val = 1'b0;
  assign I_txready = rnd_ready ? rnd_val : ready_fixed;

  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  bit   chk_on = 1'b0;
  bit   abort_exp = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mdl_buf[64];
  int   mdl_count = 0;

  pw_utmi_tx dut (
    .fe_clk       (fe_clk),
    .reset_n      (reset_n),
    .I_wr_data    (I_wr_data),
    .I_wr_en      (I_wr_en),
    .I_clear      (I_clear),
    .I_send       (I_send),
    .I_rxactive   (I_rxactive),
    .I_txready    (I_txready),
`ifdef PW_TX_CRC16_EN
    .I_append_crc (I_append_crc),
`endif
    .O_tx_data    (O_tx_data),
    .O_txvalid    (O_txvalid),
    .O_drive      (O_drive),
    .O_busy       (O_busy),
    .O_done       (O_done),
    .O_error      (O_error),
    .O_count      (O_count)
  );

  always #5 fe_clk = ~fe_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CRC16-USB, bit-serial reflected form, final inversion.
  function automatic logic [15:0] mdl_crc(input logic [7:0] bytes[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (bytes[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ bytes[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return ~c;
  endfunction

  // Random TxReady source, roughly one cycle in three.
  initial begin
    forever begin
      @(posedge fe_clk);
      #1;
      rnd_val = ($urandom_range(0, 2) == 0);
    end
  end

  // Per-cycle compare against the expected byte queue.
  always @(negedge fe_clk) begin
    if (reset_n && chk_on) begin
      if (O_txvalid) begin
        chk("drive_with_txvalid", O_drive, 1);
        chk("busy_with_txvalid", O_busy, 1);
        if (exp_q.size() == 0) begin
          chk("txvalid_after_last", O_txvalid, 0);
        end else begin
          chk("tx_data", O_tx_data, exp_q[0]);
          if (I_txready) void'(exp_q.pop_front());
        end
      end
      if (O_done) begin
        done_cnt++;
        chk("txvalid_at_done", O_txvalid, 0);
        chk("drive_at_done", O_drive, 0);
        if (!abort_exp) chk("bytes_left_at_done", exp_q.size(), 0);
      end
    end
  end

  task automatic step();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic load(input logic [7:0] b);
    I_wr_en = 1'b1;
    I_wr_data = b;
    step();
    I_wr_en = 1'b0;
    if (mdl_count < 64) begin
      mdl_buf[mdl_count] = b;
      mdl_count++;
    end
  endtask

  task automatic clear_buf();
    I_clear = 1'b1;
    step();
    I_clear = 1'b0;
    mdl_count = 0;
  endtask

  task automatic send_pkt(input bit with_crc);
    logic [7:0]  body[$];
    logic [15:0] c;
    body.delete();
    for (int i = 0; i < mdl_count; i++) begin
      exp_q.push_back(mdl_buf[i]);
      if (i > 0) body.push_back(mdl_buf[i]);
    end
    if (with_crc) begin
      c = mdl_crc(body);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
    end
`ifdef PW_TX_CRC16_EN
    I_append_crc = with_crc;
`endif
    I_send = 1'b1;
    step();
    I_send = 1'b0;
  endtask

  task automatic wait_txvalid(input string name, output int n);
    n = 1;
    while (!O_txvalid && n < 200) begin
      step();
      n++;
    end
    chk(name, O_txvalid, 1);
  endtask

  task automatic wait_done(input string name, input int bound);
    int k;
    k = 0;
    while (!O_done && k < bound) begin
      step();
      k++;
    end
    chk(name, O_done, 1);
    step();
    chk({name, "_idle"}, O_busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, d0;
    logic [7:0] q9[$];
    string s9;

    // model pins: empty body -> 0000, catalogue check value -> B4C8
    q9.delete();
    chk("crc_model_empty", mdl_crc(q9), 16'h0000);
    s9 = "123456789";
    for (int i = 0; i < s9.len(); i++) q9.push_back(s9[i]);
    chk("crc_model_check", mdl_crc(q9), 16'hB4C8);

    // reset state
    repeat (3) step();
    chk("rst_txvalid", O_txvalid, 0);
    chk("rst_drive", O_drive, 0);
    chk("rst_busy", O_busy, 0);
    chk("rst_done", O_done, 0);
    chk("rst_error", O_error, 0);
    chk("rst_count", O_count, 0);
    reset_n = 1'b1;
    step();
    chk_on = 1'b1;

    // 1: single-byte ACK, ready tied high
    load(8'hD2);
    chk("t1_count", O_count, 1);
    ready_fixed = 1'b1;
    send_pkt(1'b0);
    chk("t1_busy", O_busy, 1);
    wait_txvalid("t1_txvalid", n);
    chk("t1_latency", n, 9);
    chk("t1_byte", O_tx_data, 8'hD2);
    wait_done("t1_done", 20);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_count_after", O_count, 1);
    chk("t1_error", O_error, 0);
    $display("t1 single byte: latency %0d", n);

    // 2: DATA0 + 3 bytes, random ready
    clear_buf();
    chk("t2_cleared", O_count, 0);
    load(8'hC3); load(8'h01); load(8'h02); load(8'h03);
    chk("t2_count", O_count, 4);
    rnd_ready = 1'b1;
    send_pkt(1'b0);
    wait_done("t2_done", 500);
    rnd_ready = 1'b0;
    chk("t2_done_cnt", done_cnt, 2);
    $display("t2 four bytes random ready");

    // 3: bus busy for 20 cycles after send
    ready_fixed = 1'b1;
    I_rxactive = 1'b1;
    send_pkt(1'b0);
    n = 1;
    while (n < 100) begin
      if (n == 21) I_rxactive = 1'b0;
      if (O_txvalid) break;
      step();
      n++;
    end
    chk("t3_latency", n, 29);
    wait_done("t3_done", 50);
    $display("t3 rxactive gap: latency %0d", n);

    // 4: txready never asserted -> timeout abort
    clear_buf();
    load(8'h4B); load(8'h11);
    ready_fixed = 1'b0;
    abort_exp = 1'b1;
    send_pkt(1'b0);
    hi = 0;
    n = 0;
    while (!O_done && n < 6000) begin
      if (O_txvalid) hi++;
      step();
      n++;
    end
    chk("t4_done", O_done, 1);
    chk("t4_txvalid_cycles", hi, 4096);
    chk("t4_error", O_error, 1);
    chk("t4_drive", O_drive, 0);
    step();
    abort_exp = 1'b0;
    exp_q.delete();
    chk("t4_error_sticky", O_error, 1);
    ready_fixed = 1'b1;
    send_pkt(1'b0);
    chk("t4_error_cleared", O_error, 0);
    wait_done("t4_resend_done", 50);
    $display("t4 timeout: txvalid cycles %0d", hi);

`ifdef PW_TX_CRC16_EN
    // 5: CRC appended
    clear_buf();
    load(8'hC3);
    send_pkt(1'b1);
    chk("t5_exp_len", exp_q.size(), 3);
    wait_done("t5_pid_only_done", 50);
    clear_buf();
    load(8'h4B);
    for (int i = 0; i < 8; i++) load(8'($urandom_range(0, 255)));
    rnd_ready = 1'b1;
    send_pkt(1'b1);
    wait_done("t5_data_crc_done", 800);
    rnd_ready = 1'b0;
    $display("t5 crc append");
`endif

    // 6: overflow, busy-ignored inputs, reset mid-packet
    ready_fixed = 1'b1;
    clear_buf();
    for (int i = 0; i < 70; i++) load(8'(i * 7 + 3));
    chk("t6_count_cap", O_count, 64);
    chk("t6_model_cap", O_count, mdl_count);
    rnd_ready = 1'b1;
    d0 = done_cnt;
    send_pkt(1'b0);
    wait_txvalid("t6_txvalid", n);
    I_wr_en = 1'b1; I_wr_data = 8'h55; I_send = 1'b1;
    step();
    I_wr_en = 1'b0; I_send = 1'b0; I_clear = 1'b1;
    step();
    I_clear = 1'b0;
    chk("t6_count_busy", O_count, 64);
    wait_done("t6_done", 3000);
    rnd_ready = 1'b0;
    chk("t6_one_done", done_cnt - d0, 1);
    chk("t6_count_after", O_count, 64);

    send_pkt(1'b0);
    wait_txvalid("t6b_txvalid", n);
    repeat (5) step();
    chk("t6b_sending", O_txvalid, 1);
    reset_n = 1'b0;
    step();
    chk("t6b_rst_txvalid", O_txvalid, 0);
    chk("t6b_rst_drive", O_drive, 0);
    chk("t6b_rst_count", O_count, 0);
    chk("t6b_rst_busy", O_busy, 0);
    reset_n = 1'b1;
    exp_q.delete();
    mdl_count = 0;
    step();
    chk("t6b_idle_after", O_txvalid, 0);
    $display("t6 overflow / busy ignore / reset mid-packet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
